lc3_mem_unit: RTL and testbench
===============================

Name: lc3_mem_unit

Overview:
Parametrised successor to the single-cycle MAR/MDR/RAM path in the LC-3 datapath top. Holds MAR and MDR and an internal word-addressed RAM, and services FSM-driven read/write accesses with a configurable number of wait states. Returns a READY handshake to the control FSM. Sits between the shared BUS (bus-side input, MDR output to the existing tristate) and the control FSM.

Parameters:
DATA_W, 16, word width of BUS, MAR, MDR and RAM
ADDR_W, 16, MAR width
MEM_DEPTH, 1024, RAM words; index = MAR mod MEM_DEPTH (power of 2 required)
WAIT_STATES, 2, extra cycles before READY on RAM accesses (0 legal)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-low
BUS_IN  input  DATA_W  current BUS value
LD_MAR  input  1  MAR <= BUS_IN[ADDR_W-1:0]
LD_MDR  input  1  MDR load enable (source depends on MIO_EN)
MIO_EN  input  1  memory access request, held by FSM until READY
WE  input  1  1 = write, 0 = read; sampled with MIO_EN
MAR_OUT  output  ADDR_W  MAR contents
MDR_OUT  output  DATA_W  MDR contents (feeds BUS tristate)
READY  output  1  access-complete strobe to FSM
kbd_valid  input  1  keyboard char strobe (MMIO only)
kbd_data  input  8  keyboard char
dsp_ready  input  1  display can accept char
dsp_valid  output  1  one-cycle display write strobe
dsp_data  output  8  display char

Behaviour:
- Reset (RST=0 at an edge): MAR=0, MDR=0, state IDLE, READY=0, dsp_valid=0, dsp_data=0, KBSR full flag=0. RAM contents untouched. Reset mid-access aborts it with no write and no MDR update.
- MAR loads on LD_MAR at any time. An access in flight uses the address and write data snapshotted at IDLE->WAIT, so later MAR/MDR loads do not affect it.
- MDR loads BUS_IN when LD_MDR=1 and MIO_EN=0. With MIO_EN=1, MDR loads only read data, at the READY edge and only if LD_MDR=1.
- FSM states:
  - IDLE: MIO_EN=1 -> WAIT; cnt <= WAIT_STATES; snapshot addr, WE and MDR.
  - WAIT: MIO_EN=0 -> IDLE (abort: no write, no READY). cnt!=0 -> cnt-1. cnt==0 -> READY=1 (combinational from state/cnt); at that edge perform the write or the MDR load, then -> DONE.
  - DONE: READY=0; wait for MIO_EN=0 -> IDLE. Prevents a second access while the FSM is still in its access state.
- Latency: MIO_EN first sampled at edge 0 -> READY high in cycle WAIT_STATES+1, for exactly one cycle.
- Write: RAM[addr mod MEM_DEPTH] <= snapshot MDR at the READY edge. Read data is the RAM word at the snapshot address.
- Back-to-back accesses need at least one cycle with MIO_EN=0 between them.
- Address wrap: MAR=MEM_DEPTH+k aliases to word k.

Optional Feature:
Macro LC3_MMIO_EN.
- Defined: addresses 0xFE00 KBSR, 0xFE02 KBDR, 0xFE04 DSR and 0xFE06 DDR decode to device registers. These accesses ignore WAIT_STATES (READY in cycle 1) and never touch RAM.
  - KBSR read = {kbd_full, 15'b0}.
  - KBDR read = {8'b0, char} and clears kbd_full at the READY edge.
  - kbd_valid while not full latches kbd_data and sets kbd_full. kbd_valid while full is dropped. If a KBDR-read clear and a new kbd_valid land on the same edge, the new char is latched and kbd_full stays 1.
  - DSR read = {dsp_ready, 15'b0}.
  - DDR write pulses dsp_valid for one cycle with dsp_data = MDR[7:0].
  - Writes to KBSR/KBDR/DSR complete but are ignored.
- Undefined: those addresses are ordinary RAM. dsp_valid and dsp_data are tied to 0; kbd inputs and dsp_ready are ignored.

Decomposition:
- Package lc3_mem_pkg: state enum (IDLE, WAIT, DONE) and MMIO address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR).
- Sub-module lc3_mmio_regs: keyboard/display registers plus address decode. Instantiated only under LC3_MMIO_EN.

Test Plan:
- WAIT_STATES=2: LD_MAR with BUS=0x0010, LD_MDR with BUS=0xBEEF, then MIO_EN=1/WE=1 -> READY high in cycle 3 only. A following read of 0x0010 with LD_MDR=1 -> MDR_OUT=0xBEEF.
- WAIT_STATES=0 read -> READY in cycle 1. MIO_EN held 3 extra cycles -> READY stays low, exactly one access.
- Drop MIO_EN in WAIT cycle 1 of a write to 0x0020 (old value 0x1234) -> no READY, readback 0x1234. Assert RST low during WAIT -> MAR=0, MDR=0, READY=0 next cycle.
- MEM_DEPTH=1024: write 0x5A5A to 0x0405 -> read of 0x0005 returns 0x5A5A. LD_MAR to 0x0300 during an in-flight read of 0x0005 -> data still from 0x0005.
- LC3_MMIO_EN: kbd_valid with 0x41 -> KBSR read 0x8000. KBDR read 0x0041, then KBSR 0x0000. Second char while full is dropped.
- LC3_MMIO_EN, WAIT_STATES=3: write 0x0048 to 0xFE06 -> READY cycle 1, dsp_valid one cycle with dsp_data=0x48, RAM unchanged.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and constants for the LC-3 memory unit.
//   state_t      - access FSM states (IDLE, WAIT, DONE)
//   *_ADDR       - memory-mapped device register addresses, used only when
//                  the design is built with LC3_MMIO_EN defined.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: keyboard/display device registers and their address decode.
// Instantiated by lc3_mem_unit only when LC3_MMIO_EN is defined.
// Ports:
//   CLK, RST              clock, synchronous active-low reset
//   mar                   current MAR, decoded to choose the wait-state count
//   acc_addr, acc_we      snapshot address / direction of the access in flight
//   access                high on the completing (READY) cycle of an access
//   wr_char               low byte of the snapshot write data
//   kbd_valid, kbd_data   keyboard character strobe and value
//   dsp_ready             display can accept a character
//   mar_is_mmio           mar hits a device register
//   acc_is_mmio           acc_addr hits a device register
//   rd_data               device register read value for acc_addr
//   dsp_valid, dsp_data   one-cycle display write strobe and character
module lc3_mmio_regs
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] mar,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              acc_we,
  input  logic              access,
  input  logic [7:0]        wr_char,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  input  logic              dsp_ready,
  output logic              mar_is_mmio,
  output logic              acc_is_mmio,
  output logic [DATA_W-1:0] rd_data,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data
);

  function automatic logic is_dev(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(KBSR_ADDR)) || (a == ADDR_W'(KBDR_ADDR)) ||
           (a == ADDR_W'(DSR_ADDR))  || (a == ADDR_W'(DDR_ADDR));
  endfunction

  logic       kbd_full;
  logic [7:0] kbd_char;
  logic       kbd_clr;

  assign mar_is_mmio = is_dev(mar);
  assign acc_is_mmio = is_dev(acc_addr);
  assign kbd_clr     = access && !acc_we && (acc_addr == ADDR_W'(KBDR_ADDR));

  // A new character may land on the same edge that a KBDR read drains the
  // buffer; the new character wins and the full flag stays set.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      kbd_full  <= 1'b0;
      kbd_char  <= '0;
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
    end else begin
      if (kbd_valid && (!kbd_full || kbd_clr)) begin
        kbd_full <= 1'b1;
        kbd_char <= kbd_data;
      end else if (kbd_clr) begin
        kbd_full <= 1'b0;
      end
      dsp_valid <= access && acc_we && (acc_addr == ADDR_W'(DDR_ADDR));
      if (access && acc_we && (acc_addr == ADDR_W'(DDR_ADDR))) begin
        dsp_data <= wr_char;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise the unlisted paths infer a latch.
  always_comb begin
    rd_data = '0;
    if (acc_addr == ADDR_W'(KBSR_ADDR)) rd_data[DATA_W-1] = kbd_full;
    if (acc_addr == ADDR_W'(KBDR_ADDR)) rd_data[7:0]      = kbd_char;
    if (acc_addr == ADDR_W'(DSR_ADDR))  rd_data[DATA_W-1] = dsp_ready;
  end

endmodule

// File: rtl/lc3_mem_unit.sv
// lc3_mem_unit: MAR/MDR plus word-addressed RAM for the LC-3 datapath, with
// a wait-state access FSM and a READY handshake to the control FSM.
// Optional device registers (keyboard/display) are compiled in when the
// macro LC3_MMIO_EN is defined; otherwise those addresses are plain RAM.
// Ports:
//   CLK, RST             clock, synchronous active-low reset
//   BUS_IN               current BUS value
//   LD_MAR, LD_MDR       MAR / MDR load enables
//   MIO_EN, WE           access request (held until READY) and direction
//   MAR_OUT, MDR_OUT     register contents (MDR feeds the BUS tristate)
//   READY                one-cycle access-complete strobe
//   kbd_valid, kbd_data  keyboard character input (device build only)
//   dsp_ready            display ready (device build only)
//   dsp_valid, dsp_data  display write strobe and character
module lc3_mem_unit
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] BUS_IN,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              WE,
  output logic [ADDR_W-1:0] MAR_OUT,
  output logic [DATA_W-1:0] MDR_OUT,
  output logic              READY,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  input  logic              dsp_ready,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] snap_addr;
  logic              snap_we;
  logic [DATA_W-1:0] snap_wdata;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              ready;
  logic              mar_is_mmio;
  logic              acc_is_mmio;
  logic [DATA_W-1:0] mmio_rdata;
  logic [DATA_W-1:0] rd_data;

  assign MAR_OUT = mar;
  assign MDR_OUT = mdr;
  assign READY   = ready;
  assign idx     = snap_addr[IDX_W-1:0];  // power-of-2 depth: mod is a slice

  // Gated by MIO_EN so an abort on the final wait cycle never signals READY.
  assign ready   = (state == WAIT) && (cnt == '0) && MIO_EN;
  assign rd_data = acc_is_mmio ? mmio_rdata : mem[idx];

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      snap_addr  <= '0;
      snap_we    <= 1'b0;
      snap_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (MIO_EN) begin
          state      <= WAIT;
          cnt        <= mar_is_mmio ? '0 : CNT_INIT;
          snap_addr  <= mar;
          snap_we    <= WE;
          snap_wdata <= mdr;
        end
        WAIT: begin
          if (!MIO_EN)         state <= IDLE;
          else if (cnt != '0)  cnt   <= cnt - 1'b1;
          else                 state <= DONE;
        end
        DONE:    if (!MIO_EN) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (LD_MAR) mar <= BUS_IN[ADDR_W-1:0];
      if (LD_MDR && !MIO_EN)               mdr <= BUS_IN;
      else if (LD_MDR && ready && !snap_we) mdr <= rd_data;
    end
  end

  // NOTE: the RAM array has no reset; contents survive RST and only the
  // write is qualified by it, so a reset edge never commits a pending write.
  always_ff @(posedge CLK) begin
    if (RST && ready && snap_we && !acc_is_mmio) mem[idx] <= snap_wdata;
  end

`ifdef LC3_MMIO_EN
  lc3_mmio_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mmio (
    .CLK         (CLK),
    .RST         (RST),
    .mar         (mar),
    .acc_addr    (snap_addr),
    .acc_we      (snap_we),
    .access      (ready),
    .wr_char     (snap_wdata[7:0]),
    .kbd_valid   (kbd_valid),
    .kbd_data    (kbd_data),
    .dsp_ready   (dsp_ready),
    .mar_is_mmio (mar_is_mmio),
    .acc_is_mmio (acc_is_mmio),
    .rd_data     (mmio_rdata),
    .dsp_valid   (dsp_valid),
    .dsp_data    (dsp_data)
  );
`else
  // Device inputs are intentionally unconnected in the RAM-only build.
  logic unused_dev;
  assign unused_dev  = ^{kbd_valid, kbd_data, dsp_ready, snap_addr};
  assign mar_is_mmio = 1'b0;
  assign acc_is_mmio = 1'b0;
  assign mmio_rdata  = '0;
  assign dsp_valid   = 1'b0;
  assign dsp_data    = '0;
`endif

endmodule

// File: tb/tb_lc3_mem_unit.sv
// tb_lc3_mem_unit: directed self-checking bench for lc3_mem_unit.
// Instances: u_ws2 (WAIT_STATES=2), u_ws0 (WAIT_STATES=0) and, in the
// LC3_MMIO_EN build, u_ws3 (WAIT_STATES=3). Inputs are shared; MIO_EN is
// steered to one instance at a time by sel. Inputs change and outputs are
// sampled on the falling edge.
module tb_lc3_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n, ld_mar, ld_mdr, mio_en, we, kbd_valid, dsp_ready;
  logic [15:0] bus;
  logic [7:0]  kbd_data;
  int          sel;

  logic [15:0] mar_o [3];
  logic [15:0] mdr_o [3];
  logic        rdy   [3];
  logic        dsp_v [3];
  logic [7:0]  dsp_d [3];

  int          tests = 0;
  int          fails = 0;
  int          rc, rn, dcnt;
  logic [7:0]  dlast;

  always #5 clk = ~clk;

  lc3_mem_unit #(.WAIT_STATES(2)) u_ws2 (
    .CLK(clk), .RST(rst_n), .BUS_IN(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .MIO_EN(mio_en && sel == 0), .WE(we), .MAR_OUT(mar_o[0]),
    .MDR_OUT(mdr_o[0]), .READY(rdy[0]), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .dsp_ready(dsp_ready), .dsp_valid(dsp_v[0]),
    .dsp_data(dsp_d[0])
  );

  lc3_mem_unit #(.WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RST(rst_n), .BUS_IN(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .MIO_EN(mio_en && sel == 1), .WE(we), .MAR_OUT(mar_o[1]),
    .MDR_OUT(mdr_o[1]), .READY(rdy[1]), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .dsp_ready(dsp_ready), .dsp_valid(dsp_v[1]),
    .dsp_data(dsp_d[1])
  );

`ifdef LC3_MMIO_EN
  lc3_mem_unit #(.WAIT_STATES(3)) u_ws3 (
    .CLK(clk), .RST(rst_n), .BUS_IN(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .MIO_EN(mio_en && sel == 2), .WE(we), .MAR_OUT(mar_o[2]),
    .MDR_OUT(mdr_o[2]), .READY(rdy[2]), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .dsp_ready(dsp_ready), .dsp_valid(dsp_v[2]),
    .dsp_data(dsp_d[2])
  );
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mar(input logic [15:0] v);
    bus = v; ld_mar = 1'b1;
    @(negedge clk);
    ld_mar = 1'b0;
  endtask

  task automatic set_mdr(input logic [15:0] v);
    bus = v; ld_mdr = 1'b1;
    @(negedge clk);
    ld_mdr = 1'b0;
  endtask

  task automatic kbd_send(input logic [7:0] c);
    kbd_data = c; kbd_valid = 1'b1;
    @(negedge clk);
    kbd_valid = 1'b0;
  endtask

  // Holds MIO_EN for 8 cycles (well past READY), recording the first READY
  // cycle (cycle 1 follows the edge that first samples MIO_EN), the number
  // of READY cycles and any display strobes.
  task automatic access(input int d, input logic w, input logic ld);
    rc = 0; rn = 0; dcnt = 0; dlast = '0;
    sel = d; we = w; ld_mdr = ld; mio_en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        if (rn == 0) rc = n;
        rn++;
      end
      if (dsp_v[d] === 1'b1) begin
        dcnt++;
        dlast = dsp_d[d];
      end
    end
    mio_en = 1'b0; ld_mdr = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; we = 1'b0;
    kbd_valid = 1'b0; kbd_data = '0; dsp_ready = 1'b0; bus = '0; sel = 0;
    repeat (2) @(negedge clk);
    check("rst_mar",   mar_o[0], 16'h0000);
    check("rst_mdr",   mdr_o[0], 16'h0000);
    check("rst_ready", rdy[0],   1'b0);
    check("rst_dsp_v", dsp_v[0], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read with two wait states.
    set_mar(16'h0010); set_mdr(16'hBEEF);
    check("ld_mar", mar_o[0], 16'h0010);
    check("ld_mdr", mdr_o[0], 16'hBEEF);
    access(0, 1'b1, 1'b0);
    check("ws2_wr_ready_cycle", rc, 3);
    check("ws2_wr_ready_count", rn, 1);
    set_mdr(16'h0000);
    access(0, 1'b0, 1'b1);
    check("ws2_rd_ready_cycle", rc, 3);
    check("ws2_rd_data", mdr_o[0], 16'hBEEF);

    // Zero wait states; MIO_EN held long after READY gives one access.
    set_mdr(16'h7777);
    access(1, 1'b1, 1'b0);
    check("ws0_wr_ready_cycle", rc, 1);
    check("ws0_wr_ready_count", rn, 1);
    set_mdr(16'h0000);
    access(1, 1'b0, 1'b1);
    check("ws0_rd_ready_cycle", rc, 1);
    check("ws0_rd_data", mdr_o[1], 16'h7777);

    // Abort a write by dropping MIO_EN in wait cycle 1.
    set_mar(16'h0020); set_mdr(16'h1234);
    access(0, 1'b1, 1'b0);
    set_mdr(16'hDEAD);
    sel = 0; we = 1'b1; mio_en = 1'b1;
    @(negedge clk);
    seen = rdy[0];
    mio_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rdy[0];
    end
    we = 1'b0;
    check("abort_no_ready", seen, 1'b0);
    set_mdr(16'h0000);
    access(0, 1'b0, 1'b1);
    check("abort_readback", mdr_o[0], 16'h1234);

    // Reset on the READY edge of a write: no write, registers cleared.
    set_mdr(16'h9999);
    sel = 0; we = 1'b1; mio_en = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_ready", rdy[0], 1'b1);
    rst_n = 1'b0; mio_en = 1'b0; we = 1'b0;
    @(negedge clk);
    check("midrst_mar",   mar_o[0], 16'h0000);
    check("midrst_mdr",   mdr_o[0], 16'h0000);
    check("midrst_ready", rdy[0],   1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    set_mar(16'h0020);
    access(0, 1'b0, 1'b1);
    check("midrst_readback", mdr_o[0], 16'h1234);

    // Address wrap at MEM_DEPTH=1024.
    set_mar(16'h0405); set_mdr(16'h5A5A);
    access(0, 1'b1, 1'b0);
    set_mar(16'h0300); set_mdr(16'h1111);
    access(0, 1'b1, 1'b0);
    set_mar(16'h0005); set_mdr(16'h0000);
    access(0, 1'b0, 1'b1);
    check("wrap_rd", mdr_o[0], 16'h5A5A);

    // MAR reload during an in-flight read must not redirect it.
    set_mdr(16'h0000);
    sel = 0; we = 1'b0; ld_mdr = 1'b1; mio_en = 1'b1;
    @(negedge clk);
    bus = 16'h0300; ld_mar = 1'b1;
    @(negedge clk);
    ld_mar = 1'b0;
    repeat (4) @(negedge clk);
    mio_en = 1'b0; ld_mdr = 1'b0;
    @(negedge clk);
    check("inflight_mar", mar_o[0], 16'h0300);
    check("inflight_rd",  mdr_o[0], 16'h5A5A);

`ifdef LC3_MMIO_EN
    dsp_ready = 1'b1;
    kbd_send(8'h41);
    set_mar(16'hFE00);
    access(2, 1'b0, 1'b1);
    check("kbsr_ready_cycle", rc, 1);
    check("kbsr_full", mdr_o[2], 16'h8000);
    kbd_send(8'h42);
    set_mar(16'hFE02);
    access(2, 1'b0, 1'b1);
    check("kbdr_char", mdr_o[2], 16'h0041);
    set_mar(16'hFE00);
    access(2, 1'b0, 1'b1);
    check("kbsr_empty", mdr_o[2], 16'h0000);
    set_mar(16'hFE04);
    access(2, 1'b0, 1'b1);
    check("dsr_ready", mdr_o[2], 16'h8000);
    set_mar(16'h0206); set_mdr(16'h3333);
    access(2, 1'b1, 1'b0);
    check("ws3_ram_ready_cycle", rc, 4);
    set_mar(16'hFE06); set_mdr(16'h0048);
    access(2, 1'b1, 1'b0);
    check("ddr_ready_cycle", rc, 1);
    check("ddr_valid_count", dcnt, 1);
    check("ddr_data", dlast, 8'h48);
    set_mar(16'h0206); set_mdr(16'h0000);
    access(2, 1'b0, 1'b1);
    check("ddr_ram_untouched", mdr_o[2], 16'h3333);
`else
    set_mar(16'hFE06); set_mdr(16'h00AA);
    access(0, 1'b1, 1'b0);
    check("fe06_ram_ready_cycle", rc, 3);
    check("fe06_no_dsp", dcnt, 0);
    set_mdr(16'h0000);
    access(0, 1'b0, 1'b1);
    check("fe06_ram_rd", mdr_o[0], 16'h00AA);
    check("dsp_data_tied", dsp_d[0], 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
